pixel_capture_fifo: RTL

//  Downstream of the readout/exposure controller. Samples two-column pixel ADC data on each ADC strobe,

---
 rtl/pixel_capture_fifo.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/pixel_capture_fifo.sv
// Pixel capture path: samples two-column ADC results on each ADC strobe rising edge,
// tags them with row and start-of-frame, buffers them in a small FIFO and streams
// them out over valid/ready. Tracks frame phases, counts frames, flags sequencing errors.
module pixel_capture_fifo #(
    parameter int unsigned ADC_WIDTH  = 8,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   NRE_1,
    input  logic                   NRE_2,
    input  logic                   ADC,
    input  logic                   expose,
    input  logic                   erase,
    input  logic [ADC_WIDTH-1:0]   pix_col1,
    input  logic [ADC_WIDTH-1:0]   pix_col2,
    input  logic                   out_ready,
    input  logic                   clear_status,
    output logic                   out_valid,
    output logic [2*ADC_WIDTH-1:0] out_data,
    output logic                   out_row,
    output logic                   out_sof,
    output logic [7:0]             frame_count,
    output logic                   frame_done,
    output logic                   overflow,
    output logic                   seq_error
);

    localparam int unsigned DATA_W = 2 * ADC_WIDTH;
    localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W  = PTR_W + 1;

    typedef struct packed {
        logic              sof;
        logic              row;
        logic [DATA_W-1:0] data;
    } entry_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EXPOSE = 2'd1,
        ST_READ   = 2'd2
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic               frame_start;
    logic               frame_end;

    logic               adc_q;
    logic               sof_pending_q;
    logic [1:0]         cap_cnt_q;

    entry_t             mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [CNT_W-1:0]   count_q;
    logic [CNT_W-1:0]   count_d;

    logic               capture;
    logic               row_ok;
    logic               cap_push;
    logic               cap_err;
    logic               fifo_full;
    logic               pop;
    logic               push_acc;
    logic               ovf_set;
    logic               done_set;
    logic               cnt_err;
    entry_t             new_entry;

    // Capture qualification, row decode and FIFO handshake
    always_comb begin
        capture   = ADC & ~adc_q;
        row_ok    = NRE_1 ^ NRE_2;
        cap_push  = capture & row_ok & (state_q == ST_READ);
        cap_err   = capture & ~(row_ok & (state_q == ST_READ));
        fifo_full = (count_q == CNT_W'(FIFO_DEPTH));
        pop       = out_valid & out_ready;
        push_acc  = cap_push & (~fifo_full | pop);
        ovf_set   = cap_push & fifo_full & ~pop;
        count_d   = count_q + CNT_W'(push_acc) - CNT_W'(pop);
        done_set  = frame_end & (cap_cnt_q == 2'd2);
        cnt_err   = frame_end & (cap_cnt_q != 2'd2);
        new_entry = '{sof: sof_pending_q, row: NRE_1, data: {pix_col2, pix_col1}};
    end

    // Frame phase next-state logic
    always_comb begin
        state_d     = state_q;
        frame_start = 1'b0;
        frame_end   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (expose) begin
                    state_d     = ST_EXPOSE;
                    frame_start = 1'b1;
                end
            end
            ST_EXPOSE: begin
                if (erase) begin
                    state_d = ST_IDLE;
                end else if (!expose) begin
                    state_d = ST_READ;
                end
            end
            ST_READ: begin
                if (erase) begin
                    state_d   = ST_IDLE;
                    frame_end = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Frame phase state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Frame bookkeeping: strobe edge detect, SOF tag, capture count, status flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            adc_q         <= 1'b0;
            sof_pending_q <= 1'b0;
            cap_cnt_q     <= 2'd0;
            frame_count   <= 8'd0;
            frame_done    <= 1'b0;
            overflow      <= 1'b0;
            seq_error     <= 1'b0;
        end else begin
            adc_q      <= ADC;
            frame_done <= done_set;
            overflow   <= ovf_set | (overflow & ~clear_status);
            seq_error  <= cap_err | cnt_err | (seq_error & ~clear_status);
            if (frame_start) begin
                frame_count   <= frame_count + 8'd1;
                sof_pending_q <= 1'b1;
                cap_cnt_q     <= 2'd0;
            end else if (cap_push) begin
                sof_pending_q <= 1'b0;
                if (cap_cnt_q != 2'd3) begin
                    cap_cnt_q <= cap_cnt_q + 2'd1;
                end
            end
        end
    end

    // FIFO pointers, occupancy and registered valid
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            out_valid <= 1'b0;
        end else begin
            if (push_acc) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q   <= count_d;
            out_valid <= (count_d != '0);
        end
    end

    // FIFO storage write
    always_ff @(posedge clk) begin
        if (push_acc) begin
            mem[wr_ptr_q] <= new_entry;
        end
    end

    // Head entry presented straight from storage
    always_comb begin
        out_sof  = mem[rd_ptr_q].sof;
        out_row  = mem[rd_ptr_q].row;
        out_data = mem[rd_ptr_q].data;
    end

endmodule
